// File: rtl/bcd_time_counter.sv
// Cascadable BCD time counter: DIGITS-wide BCD field whose most-significant digit
// tops out at TOP_MSD. Counts up or down, takes a validated parallel load, and
// either wraps (WRAP=1) or saturates with a sticky done flag (WRAP=0) at its end.
module bcd_time_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned TOP_MSD = 5,
    parameter bit          WRAP    = 1'b1
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                carry,
    output logic                done,
    output logic                load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] cnt_inc;
    logic [W-1:0] cnt_dec;
    logic         is_max;
    logic         is_zero;
    logic         load_ok;

    // Single-cycle ripple for both directions, terminal detection and load validation.
    // Stepping from MAX up gives 0 and stepping from 0 down gives MAX naturally.
    always_comb begin
        logic       rip_up;
        logic       rip_dn;
        logic [3:0] dig;
        logic [3:0] ldig;
        logic [3:0] lim;
        cnt_inc = count;
        cnt_dec = count;
        is_max  = 1'b1;
        is_zero = 1'b1;
        load_ok = 1'b1;
        rip_up  = 1'b1;
        rip_dn  = 1'b1;
        dig     = 4'd0;
        ldig    = 4'd0;
        lim     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig  = count[4*i +: 4];
            ldig = load_value[4*i +: 4];
            lim  = (i == int'(DIGITS) - 1) ? 4'(TOP_MSD) : 4'd9;
            if (dig != lim)  is_max  = 1'b0;
            if (dig != 4'd0) is_zero = 1'b0;
            if (ldig > lim)  load_ok = 1'b0;
            if (rip_up) begin
                if (dig == lim) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = dig + 4'd1;
                    rip_up = 1'b0;
                end
            end
            if (rip_dn) begin
                if (dig == 4'd0) begin
                    cnt_dec[4*i +: 4] = lim;
                end else begin
                    cnt_dec[4*i +: 4] = dig - 4'd1;
                    rip_dn = 1'b0;
                end
            end
        end
    end

    // Terminal flag follows count and the current direction without a register stage.
    assign tc = up ? is_max : is_zero;

    // Count register and pulse/sticky flags: clear > load > step > hold.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count    <= '0;
            carry    <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count <= load_value;
                    done  <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en && !done) begin
                if (tc && !WRAP) begin
                    // saturate: count holds, done latches, carry marks the 0->1 of done
                    done  <= 1'b1;
                    carry <= 1'b1;
                end else begin
                    count <= up ? cnt_inc : cnt_dec;
                    carry <= tc;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three instances (2 digits/59 wrap, 2 digits/59 saturate,
// 1 digit/9 wrap) driven by directed scenarios and a random phase, all checked against
// an integer-valued reference model.
module tb_bcd_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0] clr, en, up, ld;
    logic [2:0] tc_s, cy, dn, le;
    logic [7:0] lv0, lv1, c0, c1;
    logic [3:0] lv2, c2;

    bcd_time_counter #(.DIGITS(2), .TOP_MSD(5), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .clear_n(clr[0]), .en(en[0]), .up(up[0]), .load(ld[0]),
        .load_value(lv0), .count(c0), .tc(tc_s[0]), .carry(cy[0]), .done(dn[0]),
        .load_err(le[0]));

    bcd_time_counter #(.DIGITS(2), .TOP_MSD(5), .WRAP(1'b0)) dut_sat (
        .clk(clk), .clear_n(clr[1]), .en(en[1]), .up(up[1]), .load(ld[1]),
        .load_value(lv1), .count(c1), .tc(tc_s[1]), .carry(cy[1]), .done(dn[1]),
        .load_err(le[1]));

    bcd_time_counter #(.DIGITS(1), .TOP_MSD(9), .WRAP(1'b1)) dut_dec (
        .clk(clk), .clear_n(clr[2]), .en(en[2]), .up(up[2]), .load(ld[2]),
        .load_value(lv2), .count(c2), .tc(tc_s[2]), .carry(cy[2]), .done(dn[2]),
        .load_err(le[2]));

    // reference model: the count as a plain integer
    int m_val [3];
    bit m_done[3];
    bit m_cy  [3];
    bit m_le  [3];

    function automatic int n_dig(int k);  return (k == 2) ? 1 : 2;  endfunction
    function automatic int top_of(int k); return (k == 2) ? 9 : 5;  endfunction
    function automatic int max_of(int k); return (k == 2) ? 9 : 59; endfunction
    function automatic bit wrap_of(int k); return (k != 1);         endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] get_lv(int k);
        case (k)
            0:       return {8'h00, lv0};
            1:       return {8'h00, lv1};
            default: return {12'h000, lv2};
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(int k);
        case (k)
            0:       return {8'h00, c0};
            1:       return {8'h00, c1};
            default: return {12'h000, c2};
        endcase
    endfunction

    task automatic set_lv(int k, logic [15:0] v);
        case (k)
            0:       lv0 = v[7:0];
            1:       lv1 = v[7:0];
            default: lv2 = v[3:0];
        endcase
    endtask

    function automatic void model_step(int k);
        logic [15:0] b = get_lv(k);
        bit ok = 1'b1;
        int v = 0;
        for (int i = n_dig(k) - 1; i >= 0; i--) begin
            int d = int'(b[4*i +: 4]);
            if (d > ((i == n_dig(k) - 1) ? top_of(k) : 9)) ok = 1'b0;
            v = v * 10 + d;
        end
        m_cy[k] = 1'b0;
        m_le[k] = 1'b0;
        if (!clr[k]) begin
            m_val[k]  = 0;
            m_done[k] = 1'b0;
        end else if (ld[k]) begin
            if (ok) begin
                m_val[k]  = v;
                m_done[k] = 1'b0;
            end else begin
                m_le[k] = 1'b1;
            end
        end else if (en[k] && !m_done[k]) begin
            int lim = up[k] ? max_of(k) : 0;
            if (m_val[k] == lim) begin
                m_cy[k] = 1'b1;
                if (wrap_of(k)) m_val[k] = up[k] ? 0 : max_of(k);
                else            m_done[k] = 1'b1;
            end else begin
                m_val[k] = up[k] ? m_val[k] + 1 : m_val[k] - 1;
            end
        end
    endfunction

    task automatic clk_edge();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic idle_all();
        clr = 3'b111; en = '0; up = 3'b111; ld = '0;
    endtask

    task automatic test_reset();
        idle_all();
        clr = 3'b000;
        clk_edge();
        clr = 3'b111;
        ld[0] = 1'b1; set_lv(0, 16'h0037);
        clk_edge();
        ld[0] = 1'b0;
        total++;
        if (c0 !== 8'h37) begin bad++; $display("FAIL reset_preload got=%h exp=37", c0); end
        clr = 3'b000;
        clk_edge();
        clr = 3'b111;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (get_cnt(k) !== 16'h0 || cy[k] !== 1'b0 || dn[k] !== 1'b0 || le[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset inst=%0d got cnt=%h cy=%b dn=%b le=%b exp 0/0/0/0",
                         k, get_cnt(k), cy[k], dn[k], le[k]);
            end
        end
    endtask

    task automatic test_up_wrap();
        idle_all();
        ld[0] = 1'b1; set_lv(0, 16'h0058);
        clk_edge();
        ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
        clk_edge();
        total++;
        if (c0 !== 8'h59 || tc_s[0] !== 1'b1 || cy[0] !== 1'b0) begin
            bad++; $display("FAIL up_wrap_59 got cnt=%h tc=%b cy=%b exp 59/1/0", c0, tc_s[0], cy[0]);
        end
        clk_edge();
        en[0] = 1'b0;
        total++;
        if (c0 !== 8'h00 || cy[0] !== 1'b1) begin
            bad++; $display("FAIL up_wrap_00 got cnt=%h cy=%b exp 00/1", c0, cy[0]);
        end
        clk_edge();
        total++;
        if (c0 !== 8'h00 || cy[0] !== 1'b0) begin
            bad++; $display("FAIL up_wrap_pulse got cnt=%h cy=%b exp 00/0", c0, cy[0]);
        end
    endtask

    task automatic test_down_saturate();
        logic [7:0] exp_c [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
        logic       exp_d [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_y [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        idle_all();
        ld[1] = 1'b1; set_lv(1, 16'h0002);
        clk_edge();
        ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            clk_edge();
            total++;
            if (c1 !== exp_c[s] || dn[1] !== exp_d[s] || cy[1] !== exp_y[s]) begin
                bad++;
                $display("FAIL down_sat step=%0d got cnt=%h dn=%b cy=%b exp %h/%b/%b",
                         s, c1, dn[1], cy[1], exp_c[s], exp_d[s], exp_y[s]);
            end
        end
        en[1] = 1'b0; ld[1] = 1'b1; set_lv(1, 16'h0010);
        clk_edge();
        ld[1] = 1'b0;
        total++;
        if (c1 !== 8'h10 || dn[1] !== 1'b0) begin
            bad++; $display("FAIL down_sat_release got cnt=%h dn=%b exp 10/0", c1, dn[1]);
        end
    endtask

    task automatic test_invalid_load();
        logic [15:0] bad_vals [2] = '{16'h006A, 16'h000C};
        idle_all();
        ld[0] = 1'b1; set_lv(0, 16'h0021);
        clk_edge();
        for (int j = 0; j < 2; j++) begin
            ld[0] = 1'b1; set_lv(0, bad_vals[j]);
            clk_edge();
            ld[0] = 1'b0;
            total++;
            if (c0 !== 8'h21 || le[0] !== 1'b1) begin
                bad++; $display("FAIL bad_load val=%h got cnt=%h le=%b exp 21/1", bad_vals[j], c0, le[0]);
            end
            clk_edge();
            total++;
            if (le[0] !== 1'b0) begin
                bad++; $display("FAIL bad_load_pulse val=%h got le=%b exp 0", bad_vals[j], le[0]);
            end
        end
    endtask

    task automatic test_priority();
        idle_all();
        ld[0] = 1'b1; en[0] = 1'b1; set_lv(0, 16'h0030);
        clk_edge();
        ld[0] = 1'b0; en[0] = 1'b0;
        total++;
        if (c0 !== 8'h30) begin bad++; $display("FAIL prio_load_en got=%h exp=30", c0); end
        clr[0] = 1'b0; ld[0] = 1'b1; set_lv(0, 16'h0045);
        clk_edge();
        clr[0] = 1'b1; ld[0] = 1'b0;
        total++;
        if (c0 !== 8'h00) begin bad++; $display("FAIL prio_clear_load got=%h exp=00", c0); end
    endtask

    task automatic test_decade();
        idle_all();
        clr[2] = 1'b0;
        clk_edge();
        clr[2] = 1'b1; en[2] = 1'b1; up[2] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            clk_edge();
            total++;
            if (c2 !== 4'(s % 10) || cy[2] !== (s == 10)) begin
                bad++; $display("FAIL decade_up step=%0d got cnt=%h cy=%b exp %0d/%b", s, c2, cy[2], s % 10, s == 10);
            end
        end
        up[2] = 1'b0;
        clk_edge();
        en[2] = 1'b0;
        total++;
        if (c2 !== 4'd9 || cy[2] !== 1'b1) begin
            bad++; $display("FAIL decade_down got cnt=%h cy=%b exp 9/1", c2, cy[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                clr[k] = ($urandom_range(0, 49) != 0);
                ld[k]  = ($urandom_range(0, 9) == 0);
                en[k]  = ($urandom_range(0, 3) != 0);
                up[k]  = ($urandom_range(0, 3) != 0) ^ (n >= 300);
                if ($urandom_range(0, 1) == 1) set_lv(k, to_bcd($urandom_range(0, max_of(k))));
                else                           set_lv(k, 16'($urandom));
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                bit exp_tc = up[k] ? (m_val[k] == max_of(k)) : (m_val[k] == 0);
                total++;
                if (tc_s[k] !== exp_tc) begin
                    bad++; $display("FAIL rand_tc n=%0d inst=%0d got=%b exp=%b", n, k, tc_s[k], exp_tc);
                end
            end
            clk_edge();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (get_cnt(k) !== to_bcd(m_val[k]) || cy[k] !== m_cy[k] ||
                    dn[k] !== m_done[k] || le[k] !== m_le[k]) begin
                    bad++;
                    $display("FAIL rand_state n=%0d inst=%0d got cnt=%h cy=%b dn=%b le=%b exp %h/%b/%b/%b",
                             n, k, get_cnt(k), cy[k], dn[k], le[k], to_bcd(m_val[k]),
                             m_cy[k], m_done[k], m_le[k]);
                end
            end
        end
    endtask

    initial begin
        lv0 = '0; lv1 = '0; lv2 = '0;
        idle_all();
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_invalid_load();
        test_priority();
        test_decade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
